// File: rtl/eth_10gbaser_phy_reset_ctrl.sv
// Reset sequencer for one 10GBASE-R PHY channel: orders PLL powerdown, TX and RX
// analog/digital resets from PLL lock, calibration, CDR lock-to-data and block lock.
module eth_10gbaser_phy_reset_ctrl #(
  parameter int unsigned PLL_PD_CYCLES = 1000,
  parameter int unsigned TX_DIG_DELAY  = 20,
  parameter int unsigned LTD_CYCLES    = 2000,
  parameter int unsigned BLK_TIMEOUT   = 65535
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tx_soft_reset,
  input  logic       i_rx_soft_reset,
  input  logic       i_pll_locked,
  input  logic       i_tx_cal_busy,
  input  logic       i_rx_cal_busy,
  input  logic       i_rx_is_lockedtodata,
  input  logic       i_rx_enh_blk_lock,
  output logic       o_pll_powerdown,
  output logic       o_tx_analogreset,
  output logic       o_tx_digitalreset,
  output logic       o_rx_analogreset,
  output logic       o_rx_digitalreset,
  output logic       o_tx_ready,
  output logic       o_rx_ready,
  output logic [7:0] o_rx_retry_count
);

  localparam int unsigned MaxA   = (PLL_PD_CYCLES > TX_DIG_DELAY) ? PLL_PD_CYCLES : TX_DIG_DELAY;
  localparam int unsigned MaxB   = (LTD_CYCLES > BLK_TIMEOUT) ? LTD_CYCLES : BLK_TIMEOUT;
  localparam int unsigned CntMax = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  localparam logic [CW-1:0] PdLast  = CW'(PLL_PD_CYCLES - 1);
  localparam logic [CW-1:0] DigLast = CW'(TX_DIG_DELAY - 1);
  localparam logic [CW-1:0] LtdLast = CW'(LTD_CYCLES - 1);
  localparam logic [CW-1:0] BlkLast = CW'((BLK_TIMEOUT == 0) ? 0 : BLK_TIMEOUT - 1);

  typedef enum logic [1:0] {TxPd, TxWait, TxAna, TxReady} tx_state_e;
  typedef enum logic [2:0] {RxReset, RxWaitCal, RxWaitLtd, RxWaitBlk, RxReady} rx_state_e;

  logic [4:0]    r_sync1, r_sync2;
  logic          w_pll_locked, w_tx_cal_busy, w_rx_cal_busy, w_ltd, w_blk;
  tx_state_e     r_tx_state, w_tx_state_d;
  rx_state_e     r_rx_state, w_rx_state_d;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_d, r_rx_cnt, w_rx_cnt_d;
  logic          w_retry_inc;
  logic          r_pll_powerdown, r_tx_analogreset, r_tx_digitalreset, r_tx_ready;
  logic          r_rx_analogreset, r_rx_digitalreset, r_rx_ready;
  logic [7:0]    r_rx_retry_count;

  // Two-flop synchronizer for the asynchronous PHY status inputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {i_pll_locked, i_tx_cal_busy, i_rx_cal_busy, i_rx_is_lockedtodata,
                  i_rx_enh_blk_lock};
      r_sync2 <= r_sync1;
    end
  end

  assign w_pll_locked  = r_sync2[4];
  assign w_tx_cal_busy = r_sync2[3];
  assign w_rx_cal_busy = r_sync2[2];
  assign w_ltd         = r_sync2[1];
  assign w_blk         = r_sync2[0];

  // TX next state; the counter only runs in the timed states and is zero on every entry.
  always_comb begin
    w_tx_state_d = r_tx_state;
    w_tx_cnt_d   = '0;
    if (i_tx_soft_reset) begin
      w_tx_state_d = TxPd;
    end else begin
      unique case (r_tx_state)
        TxPd: begin
          if (r_tx_cnt == PdLast) w_tx_state_d = TxWait;
          else                    w_tx_cnt_d   = r_tx_cnt + CW'(1);
        end
        TxWait: if (w_pll_locked && !w_tx_cal_busy) w_tx_state_d = TxAna;
        TxAna: begin
          if (!w_pll_locked)          w_tx_state_d = TxWait;
          else if (r_tx_cnt == DigLast) w_tx_state_d = TxReady;
          else                        w_tx_cnt_d   = r_tx_cnt + CW'(1);
        end
        TxReady: if (!w_pll_locked) w_tx_state_d = TxWait;
        default: w_tx_state_d = TxPd;
      endcase
    end
  end

  // RX next state; RX may not leave reset while TX still holds the PLL powered down.
  always_comb begin
    w_rx_state_d = r_rx_state;
    w_rx_cnt_d   = '0;
    w_retry_inc  = 1'b0;
    if (i_tx_soft_reset || i_rx_soft_reset) begin
      w_rx_state_d = RxReset;
    end else begin
      unique case (r_rx_state)
        RxReset:   if (r_tx_state != TxPd) w_rx_state_d = RxWaitCal;
        RxWaitCal: if (!w_rx_cal_busy) w_rx_state_d = RxWaitLtd;
        RxWaitLtd: begin
          // A drop of lock-to-data leaves the run count at zero.
          if (w_ltd) begin
            if (r_rx_cnt == LtdLast) w_rx_state_d = RxWaitBlk;
            else                     w_rx_cnt_d   = r_rx_cnt + CW'(1);
          end
        end
        RxWaitBlk: begin
          if (!w_ltd) begin
            w_rx_state_d = RxWaitLtd;
          end else if ((BLK_TIMEOUT != 0) && (r_rx_cnt == BlkLast)) begin
            w_rx_state_d = RxReset;
            w_retry_inc  = 1'b1;
          end else if (w_blk) begin
            w_rx_state_d = RxReady;
          end else begin
            w_rx_cnt_d = r_rx_cnt + CW'(1);
          end
        end
        RxReady: begin
          if (!w_ltd)      w_rx_state_d = RxWaitLtd;
          else if (!w_blk) w_rx_state_d = RxWaitBlk;
        end
        default: w_rx_state_d = RxReset;
      endcase
    end
  end

  // State, counters and outputs; outputs decode the next state so they move with it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_state        <= TxPd;
      r_rx_state        <= RxReset;
      r_tx_cnt          <= '0;
      r_rx_cnt          <= '0;
      r_pll_powerdown   <= 1'b1;
      r_tx_analogreset  <= 1'b1;
      r_tx_digitalreset <= 1'b1;
      r_tx_ready        <= 1'b0;
      r_rx_analogreset  <= 1'b1;
      r_rx_digitalreset <= 1'b1;
      r_rx_ready        <= 1'b0;
      r_rx_retry_count  <= '0;
    end else begin
      r_tx_state        <= w_tx_state_d;
      r_rx_state        <= w_rx_state_d;
      r_tx_cnt          <= w_tx_cnt_d;
      r_rx_cnt          <= w_rx_cnt_d;
      r_pll_powerdown   <= (w_tx_state_d == TxPd);
      r_tx_analogreset  <= (w_tx_state_d inside {TxPd, TxWait});
      r_tx_digitalreset <= (w_tx_state_d != TxReady);
      r_tx_ready        <= (w_tx_state_d == TxReady);
      r_rx_analogreset  <= (w_rx_state_d inside {RxReset, RxWaitCal});
      r_rx_digitalreset <= (w_rx_state_d inside {RxReset, RxWaitCal, RxWaitLtd});
      r_rx_ready        <= (w_rx_state_d == RxReady);
      if (w_retry_inc && (r_rx_retry_count != 8'hFF)) begin
        r_rx_retry_count <= r_rx_retry_count + 8'd1;
      end
    end
  end

  assign o_pll_powerdown   = r_pll_powerdown;
  assign o_tx_analogreset  = r_tx_analogreset;
  assign o_tx_digitalreset = r_tx_digitalreset;
  assign o_tx_ready        = r_tx_ready;
  assign o_rx_analogreset  = r_rx_analogreset;
  assign o_rx_digitalreset = r_rx_digitalreset;
  assign o_rx_ready        = r_rx_ready;
  assign o_rx_retry_count  = r_rx_retry_count;

endmodule
